// File: rtl/fpadd_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : fpadd_result_stage
// Purpose  : FP adder output stage. Selects the final IEEE double result from
//            the special-case decode and produces per-op and sticky flags
//            through a 2-deep valid/ready pipeline.
// Revision : 1.0  initial release
// ============================================================================
module fpadd_result_stage #(
    parameter logic [63:0] QNAN_CANON = 64'h7FF8000000000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic [3:0]  Ztype,
    input  logic        Invalid,
    input  logic        Denorm,
    input  logic [63:0] Znorm,
    input  logic        Overflow,
    input  logic        Underflow,
    input  logic        Inexact,
    input  logic [1:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] Z,
    output logic [4:0]  out_flags,
    input  logic        flags_clear,
    output logic [4:0]  sticky_flags
);

    localparam logic [63:0] c_NEG_INF  = 64'hFFF0000000000000;
    localparam logic [63:0] c_POS_INF  = 64'h7FF0000000000000;
    localparam logic [63:0] c_POS_ZERO = 64'h0000000000000000;
    localparam logic [63:0] c_NEG_ZERO = 64'h8000000000000000;
    localparam logic [63:0] c_QBIT     = 64'h0008000000000000;

    // Stage 1: registered operation inputs
    logic        r_s1_valid;
    logic [63:0] r_s1_a;
    logic [63:0] r_s1_b;
    logic [3:0]  r_s1_ztype;
    logic        r_s1_invalid;
    logic        r_s1_denorm;
    logic [63:0] r_s1_znorm;
    logic        r_s1_ovf;
    logic        r_s1_unf;
    logic        r_s1_inx;
    logic [1:0]  r_s1_rm;

    // Stage 2: output register
    logic        r_s2_valid;
    logic [63:0] r_z;
    logic [4:0]  r_flags;
    logic [4:0]  r_sticky;

    logic        w_s1_load;
    logic        w_s2_load;
    logic        w_out_xfer;
    logic        w_a_nan;
    logic        w_b_nan;
    logic [63:0] w_z;
    logic [4:0]  w_flags;

    assign w_s2_load  = r_s1_valid & (~r_s2_valid | out_ready);
    assign in_ready   = ~r_s1_valid | w_s2_load;
    assign w_s1_load  = in_valid & in_ready;
    assign w_out_xfer = r_s2_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_ztype   <= '0;
            r_s1_invalid <= 1'b0;
            r_s1_denorm  <= 1'b0;
            r_s1_znorm   <= '0;
            r_s1_ovf     <= 1'b0;
            r_s1_unf     <= 1'b0;
            r_s1_inx     <= 1'b0;
            r_s1_rm      <= '0;
        end else if (w_s1_load) begin
            r_s1_valid   <= 1'b1;
            r_s1_a       <= A;
            r_s1_b       <= B;
            r_s1_ztype   <= Ztype;
            r_s1_invalid <= Invalid;
            r_s1_denorm  <= Denorm;
            r_s1_znorm   <= Znorm;
            r_s1_ovf     <= Overflow;
            r_s1_unf     <= Underflow;
            r_s1_inx     <= Inexact;
            r_s1_rm      <= rm;
        end else if (w_s2_load) begin
            r_s1_valid   <= 1'b0;
        end
    end

    assign w_a_nan = (&r_s1_a[62:52]) & (|r_s1_a[51:0]);
    assign w_b_nan = (&r_s1_b[62:52]) & (|r_s1_b[51:0]);

    always_comb begin
        w_z = r_s1_znorm;
        case (r_s1_ztype)
            4'b0001: begin
                // NaN propagation prefers A, and always returns a quiet NaN
                if (r_s1_invalid)  w_z = QNAN_CANON;
                else if (w_a_nan)  w_z = r_s1_a | c_QBIT;
                else if (w_b_nan)  w_z = r_s1_b | c_QBIT;
                else               w_z = QNAN_CANON;
            end
            4'b0010: w_z = c_NEG_INF;
            4'b0011: w_z = c_POS_INF;
            4'b0100: w_z = c_POS_ZERO;
            4'b0101: w_z = (r_s1_rm == 2'b11) ? c_NEG_ZERO : c_POS_ZERO;
            4'b0110: w_z = c_NEG_ZERO;
            default: w_z = r_s1_znorm;
        endcase
    end

    // Rounding flags only mean something on the normal datapath
    always_comb begin
        w_flags = {r_s1_invalid, 3'b000, r_s1_denorm};
        if (r_s1_ztype == 4'b0000) begin
            w_flags[3] = r_s1_ovf;
            w_flags[2] = r_s1_unf;
            w_flags[1] = r_s1_inx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_z        <= '0;
            r_flags    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_z        <= w_z;
            r_flags    <= w_flags;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    // A clear coinciding with a transfer keeps that transfer's flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (flags_clear ? 5'b00000 : r_sticky) |
                        (w_out_xfer  ? r_flags  : 5'b00000);
        end
    end

    assign out_valid    = r_s2_valid;
    assign Z            = r_z;
    assign out_flags    = r_flags;
    assign sticky_flags = r_sticky;

endmodule
`default_nettype wire
